// File: rtl/iir_chan_sched_if.sv
// Operation bus between the channel scheduler (master) and the shared biquad datapath (slave).
// The datapath answers each op with dp_y0 combinationally in the same cycle.
interface iir_chan_sched_if #(
    parameter int DWIDTH = 24,
    parameter int CHW    = 2,
    parameter int STW    = 4
);
    logic              op_vld;
    logic [CHW-1:0]    op_ch;
    logic [STW-1:0]    op_stage;
    logic              op_first;
    logic              op_last;
    logic [DWIDTH-1:0] op_x;
    logic [DWIDTH-1:0] dp_y0;

    modport master (
        output op_vld, op_ch, op_stage, op_first, op_last, op_x,
        input  dp_y0
    );

    modport slave (
        input  op_vld, op_ch, op_stage, op_first, op_last, op_x,
        output dp_y0
    );
endinterface

// File: rtl/iir_chan_sched.sv
// Round-robin scheduler time-sharing one biquad datapath across NCH channels,
// each a cascade of CASCADE_LEVEL sections; one (channel, stage) op per cycle.
module iir_chan_sched #(
    parameter int NCH           = 4,
    parameter int CASCADE_LEVEL = 10,
    parameter int DWIDTH        = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      block_en,
    input  logic [NCH-1:0]            ch_vld,
    input  logic [NCH*DWIDTH-1:0]     ch_din,
    output logic [NCH-1:0]            ch_ovf,
    iir_chan_sched_if.master          dp,
    output logic                      dout_vld,
    output logic [$clog2(NCH)-1:0]    dout_ch,
    output logic [DWIDTH-1:0]         dout,
    output logic                      busy
);
    localparam int CHW = $clog2(NCH);
    localparam int STW = (CASCADE_LEVEL > 1) ? $clog2(CASCADE_LEVEL) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state_reg;
    logic [CHW-1:0]               ptr_reg;
    logic [CHW-1:0]               cur_ch_reg;
    logic [STW-1:0]               stage_reg;
    logic [DWIDTH-1:0]            x_lat_reg;
    logic [DWIDTH-1:0]            dout_reg;
    logic [CHW-1:0]               dout_ch_reg;
    logic                         dout_vld_reg;

    logic                         clr;
    logic                         run;
    logic                         last_stage;
    logic                         any_pend;
    logic                         grant;
    logic [CHW-1:0]               winner;
    logic [NCH-1:0]               pend;
    logic [NCH-1:0][DWIDTH-1:0]   smp;

    assign clr        = rst || !block_en;
    assign run        = (state_reg == RUN);
    assign last_stage = (stage_reg == STW'(CASCADE_LEVEL - 1));
    assign any_pend   = |pend;
    // In IDLE stage is held at 0, so a grant is possible whenever anything is pending.
    assign grant      = any_pend && (!run || last_stage);

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        int  idx;
        logic found;
        winner = ptr_reg;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && pend[CHW'(idx)]) begin
                winner = CHW'(idx);
                found  = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DWIDTH-1:0] smp_reg;
        logic              pend_reg;
        logic              ovf_reg;
        logic              win;

        assign win = grant && (winner == CHW'(gi));

        // A strobe on the channel's own grant cycle refills the slot being emptied.
        always_ff @(posedge clk) begin
            if (clr) begin
                smp_reg  <= '0;
                pend_reg <= 1'b0;
                ovf_reg  <= 1'b0;
            end else begin
                ovf_reg <= ch_vld[gi] && pend_reg && !win;
                if (ch_vld[gi] && (!pend_reg || win)) begin
                    smp_reg  <= ch_din[gi*DWIDTH +: DWIDTH];
                    pend_reg <= 1'b1;
                end else if (win) begin
                    pend_reg <= 1'b0;
                end
            end
        end

        assign pend[gi]   = pend_reg;
        assign smp[gi]    = smp_reg;
        assign ch_ovf[gi] = ovf_reg;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg    <= IDLE;
            ptr_reg      <= CHW'(NCH - 1);
            cur_ch_reg   <= '0;
            stage_reg    <= '0;
            x_lat_reg    <= '0;
            dout_reg     <= '0;
            dout_ch_reg  <= '0;
            dout_vld_reg <= 1'b0;
        end else begin
            dout_vld_reg <= 1'b0;
            if (run && last_stage) begin
                dout_reg     <= dp.dp_y0;
                dout_ch_reg  <= cur_ch_reg;
                dout_vld_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        state_reg  <= RUN;
                        cur_ch_reg <= winner;
                        x_lat_reg  <= smp[winner];
                        ptr_reg    <= winner;
                        stage_reg  <= '0;
                    end
                end
                RUN: begin
                    if (last_stage) begin
                        stage_reg <= '0;
                        if (grant) begin
                            cur_ch_reg <= winner;
                            x_lat_reg  <= smp[winner];
                            ptr_reg    <= winner;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        stage_reg <= stage_reg + STW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dp.op_vld   = run;
    assign dp.op_ch    = cur_ch_reg;
    assign dp.op_stage = stage_reg;
    assign dp.op_first = run && (stage_reg == '0);
    assign dp.op_last  = run && last_stage;
    assign dp.op_x     = x_lat_reg;
    assign busy        = run;
    assign dout_vld    = dout_vld_reg;
    assign dout_ch     = dout_ch_reg;
    assign dout        = dout_reg;
endmodule

// File: tb/tb_iir_chan_sched.sv
// Directed bench for iir_chan_sched with a datapath model dp_y0 = op_x + op_stage.
module tb_iir_chan_sched;
    localparam int NCH = 4;
    localparam int CL  = 10;
    localparam int DW  = 24;
    localparam int CHW = 2;
    localparam int STW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              block_en;
    logic [NCH-1:0]    ch_vld;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_ovf;
    logic              dout_vld;
    logic [CHW-1:0]    dout_ch;
    logic [DW-1:0]     dout;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [33:0] obs;
    logic [33:0] expv;
    logic        ev;

    iir_chan_sched_if #(.DWIDTH(DW), .CHW(CHW), .STW(STW)) bus ();

    assign bus.dp_y0 = bus.op_x + DW'(bus.op_stage);

    iir_chan_sched #(.NCH(NCH), .CASCADE_LEVEL(CL), .DWIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .block_en (block_en),
        .ch_vld   (ch_vld),
        .ch_din   (ch_din),
        .ch_ovf   (ch_ovf),
        .dp       (bus),
        .dout_vld (dout_vld),
        .dout_ch  (dout_ch),
        .dout     (dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign obs = {bus.op_vld, busy, bus.op_ch, bus.op_stage, bus.op_first, bus.op_last, bus.op_x};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        block_en = 1'b1;
        ch_vld   = '0;
        ch_din   = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.op_vld, busy, bus.op_first, bus.op_last, dout_vld} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {bus.op_vld, busy, bus.op_first, bus.op_last, dout_vld});
        end
        checks++;
        if ({dout, bus.op_x} !== '0) begin
            errors++;
            $display("FAIL reset_data: got dout=%h op_x=%h, want 0", dout, bus.op_x);
        end
        checks++;
        if ({dout_ch, bus.op_ch, bus.op_stage, ch_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_idx: got dout_ch=%0d op_ch=%0d op_stage=%0d ch_ovf=%b, want 0",
                     dout_ch, bus.op_ch, bus.op_stage, ch_ovf);
        end
        next_cycle();
        rst = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            ch_vld = (k == 0) ? 4'b0100 : 4'b0000;
            ch_din = '0;
            ch_din[2*DW +: DW] = 24'h000100;
            @(negedge clk);
            ev   = (k >= 2 && k <= 11);
            expv = {2'b11, 2'd2, 4'(k-2), (k == 2), (k == 11), 24'h000100};
            checks++;
            if (ev ? (obs !== expv) : (obs[33:32] !== 2'b00)) begin
                errors++;
                $display("FAIL single_op cycle %0d: got %h, want vld=%0b %h", k, obs, ev, expv);
            end
            checks++;
            if (dout_vld !== (k == 12) || (k == 12 && (dout !== 24'h000109 || dout_ch !== 2'd2))) begin
                errors++;
                $display("FAIL single_dout cycle %0d: got vld=%0b ch=%0d dout=%h, want vld=%0b ch=2 dout=000109",
                         k, dout_vld, dout_ch, dout, (k == 12));
            end
            if (dout_vld) $display("single: cycle %0d dout ch%0d = %h", k, dout_ch, dout);
            next_cycle();
        end
    endtask

    task automatic test_all_channels();
        int n;
        do_reset();
        for (int k = 0; k <= 44; k++) begin
            ch_vld = (k == 0) ? 4'b1111 : 4'b0000;
            ch_din = {24'h000040, 24'h000030, 24'h000020, 24'h000010};
            @(negedge clk);
            n    = (k - 2) / 10;
            ev   = (k >= 2 && k <= 41);
            expv = {2'b11, 2'(n), 4'((k-2) % 10), ((k-2) % 10 == 0), ((k-2) % 10 == 9), DW'(16*(n+1))};
            checks++;
            if (ev ? (obs !== expv) : (obs[33:32] !== 2'b00)) begin
                errors++;
                $display("FAIL all4_op cycle %0d: got %h, want vld=%0b %h", k, obs, ev, expv);
            end
            n = (k - 12) / 10;
            checks++;
            if (dout_vld !== (k == 12 || k == 22 || k == 32 || k == 42) ||
                (dout_vld && (dout !== DW'(16*(n+1) + 9) || dout_ch !== 2'(n)))) begin
                errors++;
                $display("FAIL all4_dout cycle %0d: got vld=%0b ch=%0d dout=%h", k, dout_vld, dout_ch, dout);
            end
            if (dout_vld) $display("all4: cycle %0d dout ch%0d = %h", k, dout_ch, dout);
            next_cycle();
        end
    endtask

    task automatic test_fairness();
        logic [3:0] masks  [4] = '{4'b1000, 4'b1001, 4'b0001, 4'b1001};
        int         nsrv   [4] = '{1, 2, 1, 2};
        int         order0 [4] = '{3, 0, 0, 3};
        int         order1 [4] = '{0, 3, 0, 0};
        int         got[$];
        do_reset();
        for (int p = 0; p < 4; p++) begin
            got.delete();
            for (int k = 0; k <= 4 + 10*nsrv[p]; k++) begin
                ch_vld = (k == 0) ? masks[p] : 4'b0000;
                ch_din = {24'h0003A0, 24'h0002A0, 24'h0001A0, 24'h0000A0};
                @(negedge clk);
                if (bus.op_vld === 1'b1 && bus.op_first === 1'b1) got.push_back(int'(bus.op_ch));
                next_cycle();
            end
            checks++;
            if (got.size() != nsrv[p] || got[0] != order0[p] ||
                (nsrv[p] == 2 && got[1] != order1[p])) begin
                errors++;
                $display("FAIL fair_order phase %0d: got %0d grants first=%0d, want %0d grants order %0d,%0d",
                         p, got.size(), (got.size() > 0) ? got[0] : -1, nsrv[p], order0[p], order1[p]);
            end
            $display("fairness: phase %0d served %0d channels", p, got.size());
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] x;
        do_reset();
        for (int k = 0; k <= 34; k++) begin
            ch_vld = (k == 0) ? 4'b0001 : ((k == 3 || k == 4 || k == 11) ? 4'b0010 : 4'b0000);
            ch_din = '0;
            ch_din[0 +: DW]  = 24'h000050;
            ch_din[DW +: DW] = (k == 3) ? 24'h0000A1 : ((k == 4) ? 24'h0000B2 : 24'h0000C3);
            @(negedge clk);
            ev = (k >= 2 && k <= 31);
            x  = (k < 12) ? 24'h000050 : ((k < 22) ? 24'h0000A1 : 24'h0000C3);
            expv = {2'b11, (k < 12) ? 2'd0 : 2'd1, 4'((k-2) % 10), ((k-2) % 10 == 0), ((k-2) % 10 == 9), x};
            checks++;
            if (ev ? (obs !== expv) : (obs[33:32] !== 2'b00)) begin
                errors++;
                $display("FAIL ovr_op cycle %0d: got %h, want vld=%0b %h", k, obs, ev, expv);
            end
            checks++;
            if (ch_ovf !== ((k == 5) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL ovr_flag cycle %0d: got %b, want %b", k, ch_ovf, (k == 5) ? 4'b0010 : 4'b0000);
            end
            checks++;
            if (dout_vld !== (k == 12 || k == 22 || k == 32) ||
                (k == 12 && (dout !== 24'h000059 || dout_ch !== 2'd0)) ||
                (k == 22 && (dout !== 24'h0000AA || dout_ch !== 2'd1)) ||
                (k == 32 && (dout !== 24'h0000CC || dout_ch !== 2'd1))) begin
                errors++;
                $display("FAIL ovr_dout cycle %0d: got vld=%0b ch=%0d dout=%h", k, dout_vld, dout_ch, dout);
            end
            if (dout_vld) $display("overrun: cycle %0d dout ch%0d = %h", k, dout_ch, dout);
            next_cycle();
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k <= 22; k++) begin
            ch_vld   = (k == 0) ? 4'b0100 : ((k == 8) ? 4'b1000 : 4'b0000);
            block_en = !(k >= 7 && k <= 9);
            ch_din   = {24'h000077, 24'h000070, 24'h000000, 24'h000000};
            @(negedge clk);
            ev   = (k >= 2 && k <= 7);
            expv = {2'b11, 2'd2, 4'(k-2), (k == 2), 1'b0, 24'h000070};
            checks++;
            if (ev ? (obs !== expv) : (obs[33:32] !== 2'b00)) begin
                errors++;
                $display("FAIL abort_op cycle %0d: got %h, want vld=%0b %h", k, obs, ev, expv);
            end
            checks++;
            if (dout_vld !== 1'b0 || (k >= 8 && (dout !== '0 || dout_ch !== '0))) begin
                errors++;
                $display("FAIL abort_dout cycle %0d: got vld=%0b ch=%0d dout=%h, want 0", k, dout_vld, dout_ch, dout);
            end
            if (k == 8) begin
                checks++;
                if (bus.op_x !== '0 || ch_ovf !== '0) begin
                    errors++;
                    $display("FAIL abort_clear: got op_x=%h ch_ovf=%b, want 0", bus.op_x, ch_ovf);
                end
            end
            next_cycle();
        end
        $display("abort: cascade dropped");
        for (int k = 0; k <= 13; k++) begin
            ch_vld = (k == 0) ? 4'b0100 : 4'b0000;
            ch_din = {24'h000000, 24'h000033, 24'h000000, 24'h000000};
            @(negedge clk);
            checks++;
            if (dout_vld !== (k == 12) || (k == 12 && (dout !== 24'h00003C || dout_ch !== 2'd2))) begin
                errors++;
                $display("FAIL abort_restart cycle %0d: got vld=%0b ch=%0d dout=%h, want vld=%0b ch=2 dout=00003c",
                         k, dout_vld, dout_ch, dout, (k == 12));
            end
            if (dout_vld) $display("abort restart: cycle %0d dout ch%0d = %h", k, dout_ch, dout);
            next_cycle();
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k <= 23; k++) begin
            ch_vld = (k == 0) ? 4'b0110 : ((k == 5 || k == 10) ? 4'b1111 : 4'b0000);
            rst    = (k == 5);
            ch_din = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if ({bus.op_vld, busy, bus.op_first, bus.op_last, dout_vld} !== 5'b0 ||
                    {dout, bus.op_x} !== '0 ||
                    {dout_ch, bus.op_ch, bus.op_stage, ch_ovf} !== '0) begin
                    errors++;
                    $display("FAIL rstrun_clear: got ops=%h dout_vld=%0b dout=%h dout_ch=%0d ch_ovf=%b, want all 0",
                             obs, dout_vld, dout, dout_ch, ch_ovf);
                end
            end
            if (k >= 6 && k <= 11) begin
                checks++;
                if (bus.op_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL rstrun_idle cycle %0d: got op_vld=%0b, want 0", k, bus.op_vld);
                end
            end
            if (k == 12 || k == 22) begin
                checks++;
                if (bus.op_vld !== 1'b1 || bus.op_first !== 1'b1 || bus.op_ch !== ((k == 12) ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("FAIL rstrun_grant cycle %0d: got vld=%0b first=%0b ch=%0d, want 1 1 %0d",
                             k, bus.op_vld, bus.op_first, bus.op_ch, (k == 12) ? 0 : 1);
                end
                $display("reset midrun: cycle %0d grant ch%0d", k, bus.op_ch);
            end
            next_cycle();
        end
        ch_vld = '0;
    endtask

    initial begin
        rst      = 1'b1;
        block_en = 1'b1;
        ch_vld   = '0;
        ch_din   = '0;
        test_reset();
        test_single();
        test_all_channels();
        test_fairness();
        test_overrun();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
